cache_mem_arbiter: RTL and testbench

- Shares the single cacheline physical-memory port between the I-cache and D-cache of the pipelined RV32I core.
- Serves one 256-bit line transaction at a time.
- Arbitrates simultaneous misses with alternating (last-served-loses) priority.
- Latches the winning request and flags memory responses that exceed a configurable cycle budget.

---
 rtl/cache_mem_arbiter.sv | 132 +++++++++++++
 tb/tb_cache_mem_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// Shares one cacheline memory port between the I-cache and D-cache, one line at a time,
// with alternating priority on simultaneous misses and a sticky response watchdog.
module cache_mem_arbiter #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned LINE_W   = 256,
    parameter int unsigned OFFSET_W = 5,
    parameter int unsigned TIMEOUT  = 1024
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,

    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,

    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp,

    output logic              busy,
    output logic              err
);

    localparam int unsigned WdW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] AddrMask = {{(ADDR_W - OFFSET_W){1'b1}}, {OFFSET_W{1'b0}}};

    typedef enum logic [1:0] {
        StIdle,
        StIRd,
        StDRd,
        StDWr
    } state_e;

    state_e            state_q;
    logic              last_d_q;
    logic [WdW-1:0]    wd_cnt_q;
    logic              err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic              pmem_read_q;
    logic              pmem_write_q;

    logic i_req;
    logic d_req;
    logic grant_i;
    logic grant_d;

    // On a tie the side that was not served last wins.
    always_comb begin
        i_req   = i_read;
        d_req   = d_read | d_write;
        grant_i = i_req & (~d_req | last_d_q);
        grant_d = d_req & (~i_req | ~last_d_q);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= StIdle;
            last_d_q     <= 1'b1;
            wd_cnt_q     <= '0;
            err_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (grant_i) begin
                        state_q     <= StIRd;
                        pmem_read_q <= 1'b1;
                        addr_q      <= i_address & AddrMask;
                        last_d_q    <= 1'b0;
                        wd_cnt_q    <= '0;
                    end else if (grant_d) begin
                        addr_q   <= d_address & AddrMask;
                        last_d_q <= 1'b1;
                        wd_cnt_q <= '0;
                        if (d_write) begin
                            state_q      <= StDWr;
                            pmem_write_q <= 1'b1;
                            wdata_q      <= d_wdata;
                        end else begin
                            state_q     <= StDRd;
                            pmem_read_q <= 1'b1;
                        end
                    end
                end
                StIRd, StDRd, StDWr: begin
                    if (pmem_resp) begin
                        state_q      <= StIdle;
                        pmem_read_q  <= 1'b0;
                        pmem_write_q <= 1'b0;
                    end else if (wd_cnt_q != '1) begin
                        wd_cnt_q <= wd_cnt_q + WdW'(1);
                    end
                    if ((TIMEOUT != 0) && (wd_cnt_q == WdLast)) begin
                        err_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Responses are gated by reset so an aborted transaction never completes.
    always_comb begin
        i_resp       = rst & pmem_resp & (state_q == StIRd);
        d_resp       = rst & pmem_resp & ((state_q == StDRd) | (state_q == StDWr));
        i_rdata      = pmem_rdata;
        d_rdata      = pmem_rdata;
        pmem_read    = pmem_read_q;
        pmem_write   = pmem_write_q;
        pmem_address = addr_q;
        pmem_wdata   = wdata_q;
        busy         = (state_q != StIdle);
        err          = err_q;
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: single misses, writeback, tie alternation,
// mid-flight input changes, watchdog and reset abort.
module tb_cache_mem_arbiter;

    logic         clk;
    logic         rst;
    logic         i_read;
    logic [31:0]  i_address;
    logic [255:0] i_rdata;
    logic         i_resp;
    logic         d_read;
    logic         d_write;
    logic [31:0]  d_address;
    logic [255:0] d_wdata;
    logic [255:0] d_rdata;
    logic         d_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
    logic         busy;
    logic         err;

    int n_cmp;
    int n_bad;

    logic [255:0] pat;
    logic [31:0]  exp_addr;
    logic         exp_i;

    cache_mem_arbiter #(
        .ADDR_W  (32),
        .LINE_W  (256),
        .OFFSET_W(5),
        .TIMEOUT (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_read      (i_read),
        .i_address   (i_address),
        .i_rdata     (i_rdata),
        .i_resp      (i_resp),
        .d_read      (d_read),
        .d_write     (d_write),
        .d_address   (d_address),
        .d_wdata     (d_wdata),
        .d_rdata     (d_rdata),
        .d_resp      (d_resp),
        .pmem_read   (pmem_read),
        .pmem_write  (pmem_write),
        .pmem_address(pmem_address),
        .pmem_wdata  (pmem_wdata),
        .pmem_rdata  (pmem_rdata),
        .pmem_resp   (pmem_resp),
        .busy        (busy),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        rst        = 1'b0;
        i_read     = 1'b0;
        i_address  = '0;
        d_read     = 1'b0;
        d_write    = 1'b0;
        d_address  = '0;
        d_wdata    = '0;
        pmem_rdata = '0;
        pmem_resp  = 1'b0;
        pat        = {8{32'hDEAD_BEEF}} ^ {32'h0123_4567, 224'h0};

        step();
        step();
        @(negedge clk);
        check_eq("rst_pmem_read", 256'(pmem_read), 256'(0));
        check_eq("rst_pmem_write", 256'(pmem_write), 256'(0));
        check_eq("rst_i_resp", 256'(i_resp), 256'(0));
        check_eq("rst_d_resp", 256'(d_resp), 256'(0));
        check_eq("rst_busy", 256'(busy), 256'(0));
        check_eq("rst_err", 256'(err), 256'(0));
        check_eq("rst_addr", 256'(pmem_address), 256'(0));
        check_eq("rst_wdata", pmem_wdata, 256'(0));
        step();
        rst = 1'b1;

        // Lone I miss, memory answers in cycle 5
        i_read    = 1'b1;
        i_address = 32'h0000_1234;
        @(negedge clk);
        check_eq("i0_busy", 256'(busy), 256'(0));
        step();
        @(negedge clk);
        check_eq("i1_pmem_read", 256'(pmem_read), 256'(1));
        check_eq("i1_pmem_write", 256'(pmem_write), 256'(0));
        check_eq("i1_addr", 256'(pmem_address), 256'(32'h0000_1220));
        check_eq("i1_busy", 256'(busy), 256'(1));
        check_eq("i1_i_resp", 256'(i_resp), 256'(0));
        step();
        step();
        step();
        @(negedge clk);
        check_eq("i4_i_resp", 256'(i_resp), 256'(0));
        step();
        pmem_resp  = 1'b1;
        pmem_rdata = {32{8'hA5}};
        @(negedge clk);
        check_eq("i5_i_resp", 256'(i_resp), 256'(1));
        check_eq("i5_i_rdata", i_rdata, {32{8'hA5}});
        check_eq("i5_d_resp", 256'(d_resp), 256'(0));
        step();
        i_read    = 1'b0;
        pmem_resp = 1'b0;
        @(negedge clk);
        check_eq("i6_busy", 256'(busy), 256'(0));
        check_eq("i6_i_resp", 256'(i_resp), 256'(0));
        check_eq("i6_pmem_read", 256'(pmem_read), 256'(0));

        // Writeback
        step();
        d_write   = 1'b1;
        d_address = 32'h8000_003F;
        d_wdata   = pat;
        step();
        @(negedge clk);
        check_eq("wb_pmem_write", 256'(pmem_write), 256'(1));
        check_eq("wb_pmem_read", 256'(pmem_read), 256'(0));
        check_eq("wb_addr", 256'(pmem_address), 256'(32'h8000_0020));
        check_eq("wb_wdata", pmem_wdata, pat);
        step();
        pmem_resp = 1'b1;
        @(negedge clk);
        check_eq("wb_d_resp", 256'(d_resp), 256'(1));
        check_eq("wb_i_resp", 256'(i_resp), 256'(0));
        step();
        d_write   = 1'b0;
        pmem_resp = 1'b0;
        @(negedge clk);
        check_eq("wb_idle_busy", 256'(busy), 256'(0));
        check_eq("wb_idle_d_resp", 256'(d_resp), 256'(0));

        // Mid-flight input changes during D_RD
        step();
        d_read    = 1'b1;
        d_address = 32'h0000_4440;
        step();
        @(negedge clk);
        check_eq("mf_pmem_read", 256'(pmem_read), 256'(1));
        check_eq("mf_addr1", 256'(pmem_address), 256'(32'h0000_4440));
        d_address = 32'hFFFF_FFE0;
        i_read    = 1'b1;
        i_address = 32'h0000_3000;
        step();
        @(negedge clk);
        check_eq("mf_addr2", 256'(pmem_address), 256'(32'h0000_4440));
        check_eq("mf_i_resp2", 256'(i_resp), 256'(0));
        step();
        pmem_resp = 1'b1;
        @(negedge clk);
        check_eq("mf_d_resp", 256'(d_resp), 256'(1));
        check_eq("mf_i_resp3", 256'(i_resp), 256'(0));
        check_eq("mf_addr3", 256'(pmem_address), 256'(32'h0000_4440));
        step();
        d_read    = 1'b0;
        pmem_resp = 1'b0;
        @(negedge clk);
        check_eq("mf_idle_busy", 256'(busy), 256'(0));
        step();
        pmem_resp = 1'b1;
        @(negedge clk);
        check_eq("mf_i_grant_read", 256'(pmem_read), 256'(1));
        check_eq("mf_i_grant_addr", 256'(pmem_address), 256'(32'h0000_3000));
        check_eq("mf_i_resp", 256'(i_resp), 256'(1));
        step();
        i_read    = 1'b0;
        pmem_resp = 1'b0;
        @(negedge clk);
        check_eq("mf_end_busy", 256'(busy), 256'(0));

        // Fresh reset, then both requesters held: I, D, I, D
        step();
        rst = 1'b0;
        step();
        rst       = 1'b1;
        i_read    = 1'b1;
        d_read    = 1'b1;
        i_address = 32'h0000_0100;
        d_address = 32'h0000_0200;
        for (int k = 0; k < 4; k++) begin
            exp_i    = ((k % 2) == 0);
            exp_addr = exp_i ? 32'h0000_0100 : 32'h0000_0200;
            step();
            pmem_resp = 1'b1;
            @(negedge clk);
            check_eq($sformatf("tie%0d_addr", k), 256'(pmem_address), 256'(exp_addr));
            check_eq($sformatf("tie%0d_i_resp", k), 256'(i_resp), 256'(exp_i));
            check_eq($sformatf("tie%0d_d_resp", k), 256'(d_resp), 256'(!exp_i));
            step();
            pmem_resp = 1'b0;
            @(negedge clk);
            check_eq($sformatf("tie%0d_idle", k), 256'(busy), 256'(0));
        end
        i_read = 1'b0;
        d_read = 1'b0;

        // Watchdog with TIMEOUT=8
        step();
        i_read    = 1'b1;
        i_address = 32'h0000_0500;
        repeat (8) step();
        @(negedge clk);
        check_eq("wd_busy8", 256'(busy), 256'(1));
        check_eq("wd_err8", 256'(err), 256'(0));
        step();
        @(negedge clk);
        check_eq("wd_err9", 256'(err), 256'(1));
        check_eq("wd_busy9", 256'(busy), 256'(1));
        step();
        pmem_resp  = 1'b1;
        pmem_rdata = {8{32'h5A5A_0F0F}};
        @(negedge clk);
        check_eq("wd_late_resp", 256'(i_resp), 256'(1));
        check_eq("wd_late_rdata", i_rdata, {8{32'h5A5A_0F0F}});
        step();
        i_read    = 1'b0;
        pmem_resp = 1'b0;
        @(negedge clk);
        check_eq("wd_idle_busy", 256'(busy), 256'(0));
        check_eq("wd_sticky", 256'(err), 256'(1));
        step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        @(negedge clk);
        check_eq("wd_cleared", 256'(err), 256'(0));

        // Reset during I_RD aborts the transaction
        step();
        i_read    = 1'b1;
        i_address = 32'h0000_0600;
        step();
        @(negedge clk);
        check_eq("ro_pmem_read1", 256'(pmem_read), 256'(1));
        step();
        rst       = 1'b0;
        i_read    = 1'b0;
        pmem_resp = 1'b1;
        @(negedge clk);
        check_eq("ro_resp_in_rst", 256'(i_resp), 256'(0));
        step();
        rst = 1'b1;
        @(negedge clk);
        check_eq("ro_pmem_read", 256'(pmem_read), 256'(0));
        check_eq("ro_busy", 256'(busy), 256'(0));
        check_eq("ro_i_resp", 256'(i_resp), 256'(0));
        step();
        pmem_resp = 1'b0;
        @(negedge clk);
        check_eq("ro_late_busy", 256'(busy), 256'(0));
        check_eq("ro_late_read", 256'(pmem_read), 256'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
